axi_sram_slave: RTL

- AXI responder (slave) for the memory side of the CPU's 2x1 AXI interconnect master port.
- Accepts the INCR or FIXED read bursts and write bursts issued by the instruction and data caches.
- Backs them with an internal word-addressed memory array.
- Used as the memory model in core-level simulation, and as an on-chip scratch RAM.

---
 rtl/axi_sram_slave.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI responder backed by a word-addressed SRAM array; independent read and write
// burst engines, one outstanding burst each, 1R/1W memory ports.
module axi_sram_slave #(
    parameter int unsigned MEM_DEPTH_LOG2 = 14,
    parameter int unsigned READ_WAIT      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned AW = MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem [0:(1 << AW) - 1];

    r_state_e    r_state_q, r_state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [3:0]  rwait_q, rwait_d, rid_q, rid_d;
    logic        rfixed_q, rfixed_d, rerr_q, rerr_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        present_c;

    w_state_e    w_state_q, w_state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d, wcnt_q, wcnt_d, wid_q, wid_d, bid_q, bid_d;
    logic        wfixed_q, wfixed_d, wszerr_q, wszerr_d, werr_q, werr_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        mem_we_c, wlast_exp_c;

    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

    // Read engine: a beat is "presented" whenever the next R payload must be loaded.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rwait_d   = rwait_q;
        rid_d     = rid_q;
        rfixed_d  = rfixed_q;
        rerr_d    = rerr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        present_c = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rid_d     = arid;
                    raddr_d   = araddr[AW+1:2];
                    rlen_d    = arlen;
                    rcnt_d    = 8'd0;
                    rfixed_d  = (arburst == 2'b00);
                    rerr_d    = (arsize != 3'b010) || arburst[1];
                    arready_d = 1'b0;
                    if (READ_WAIT > 0) begin
                        r_state_d = R_WAIT;
                        rwait_d   = 4'(READ_WAIT) - 4'd1;
                    end else begin
                        r_state_d = R_DATA;
                        present_c = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (rwait_q == 4'd0) begin
                    r_state_d = R_DATA;
                    present_c = 1'b1;
                end else begin
                    rwait_d = rwait_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        raddr_d   = rfixed_q ? raddr_q : raddr_q + AW'(1);
                        rcnt_d    = rcnt_q + 8'd1;
                        present_c = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (present_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rerr_d ? 32'd0 : mem[raddr_d];
            rresp_d  = rerr_d ? 2'b10 : 2'b00;
            rlast_d  = (rcnt_d == rlen_d);
        end
    end

    // Write engine: awlen decides the burst end; wlast only feeds the error flag.
    always_comb begin
        w_state_d   = w_state_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wid_d       = wid_q;
        bid_d       = bid_q;
        wfixed_d    = wfixed_q;
        wszerr_d    = wszerr_q;
        werr_d      = werr_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        mem_we_c    = 1'b0;
        wlast_exp_c = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wid_d     = awid;
                    waddr_d   = awaddr[AW+1:2];
                    wlen_d    = awlen;
                    wcnt_d    = 4'd0;
                    wfixed_d  = (awburst == 2'b00);
                    wszerr_d  = (awsize != 3'b010) || awburst[1];
                    werr_d    = (awsize != 3'b010) || awburst[1];
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we_c    = !wszerr_q;
                    wlast_exp_c = (wcnt_q == wlen_q);
                    if (wlast != wlast_exp_c) begin
                        werr_d = 1'b1;
                    end
                    if (wlast_exp_c) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = wid_q;
                        bresp_d   = werr_d ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = wfixed_q ? waddr_q : waddr_q + AW'(1);
                        wcnt_d  = wcnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rwait_q   <= 4'd0;
            rid_q     <= 4'd0;
            rfixed_q  <= 1'b0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= 4'd0;
            wcnt_q    <= 4'd0;
            wid_q     <= 4'd0;
            bid_q     <= 4'd0;
            wfixed_q  <= 1'b0;
            wszerr_q  <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rwait_q   <= rwait_d;
            rid_q     <= rid_d;
            rfixed_q  <= rfixed_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wid_q     <= wid_d;
            bid_q     <= bid_d;
            wfixed_q  <= wfixed_d;
            wszerr_q  <= wszerr_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory contents survive reset; a reset cycle drops any in-flight write beat.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr_q][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
